// File: rtl/bc_pkg.sv
// Shared sizing helpers for the multicast broadcaster and its per-branch FIFO.
package bc_pkg;

    localparam int MAX_BRANCHES = 32;

    typedef logic [MAX_BRANCHES-1:0] bc_mask_max_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A single-entry FIFO still needs a 1-bit pointer to keep the vectors legal.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dti_s_if.sv
// Valid/ready stream interface carrying a DW-bit payload.
interface dti_s_if #(
    parameter int DW = 16
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/bc_mcast_fifo.sv
// Per-branch synchronous FIFO; any DEPTH >= 1, pointers wrap at DEPTH-1.
module bc_mcast_fifo
    import bc_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);
    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (pop_ok && !push_ok) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bc_mcast.sv
// Multicast broadcaster: one input stream fanned out to SIZE masked branches,
// either FIFO-decoupled (DEPTH >= 1) or lock-step with per-branch served flags (DEPTH == 0).
module bc_mcast
    import bc_pkg::*;
#(
    parameter int SIZE  = 2,
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    dti_s_if.consumer       din,
    input  logic [SIZE-1:0] mask,
    dti_s_if.producer       dout [SIZE],
    output logic            busy
);
    logic din_hs;

    assign din_hs = din.valid & din.ready;

    if (DEPTH > 0) begin : g_buf
        logic [SIZE-1:0] full;
        logic [SIZE-1:0] empty;

        for (genvar i = 0; i < SIZE; i++) begin : g_br
            logic [DW-1:0] head;

            bc_mcast_fifo #(
                .DW    (DW),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (din_hs & mask[i]),
                .din   (din.data),
                .pop   (dout[i].ready),
                .full  (full[i]),
                .empty (empty[i]),
                .head  (head)
            );

            assign dout[i].valid = ~empty[i];
            assign dout[i].data  = head;
        end

        // Registered full only: a same-cycle pop never frees a slot for this push.
        assign din.ready = &(~mask | ~full);
        assign busy      = |(~empty);
    end else begin : g_lock
        logic [SIZE-1:0] served;
        logic [SIZE-1:0] hs;
        logic [SIZE-1:0] rdy_term;

        for (genvar i = 0; i < SIZE; i++) begin : g_br
            assign dout[i].valid = din.valid & mask[i] & ~served[i];
            assign dout[i].data  = din.data;
            assign hs[i]         = dout[i].valid & dout[i].ready;
            assign rdy_term[i]   = ~mask[i] | served[i] | dout[i].ready;
        end

        assign din.ready = &rdy_term;
        assign busy      = |served;

        always_ff @(posedge clk) begin
            if (!rst)        served <= '0;
            else if (din_hs) served <= '0;
            else             served <= served | hs;
        end
    end

endmodule
